// File: rtl/text_console_pkg.sv
// Shared constants and types for the text console controller: register
// addresses, control/status bit positions, special characters and the clear
// engine state type.
package text_console_pkg;

  localparam logic [7:0] REG_CHAR   = 8'h00;
  localparam logic [7:0] REG_CURX   = 8'h01;
  localparam logic [7:0] REG_CURY   = 8'h02;
  localparam logic [7:0] REG_CTRL   = 8'h03;
  localparam logic [7:0] REG_STATUS = 8'h04;

  localparam int CTRL_CLEAR_BIT   = 0;
  localparam int CTRL_OVF_CLR_BIT = 1;
  localparam int STATUS_BUSY_BIT  = 0;
  localparam int STATUS_OVF_BIT   = 1;

  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] FILL_RESET = 8'h20;

  typedef enum logic [0:0] {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_t;

endpackage

// File: rtl/text_console_if.sv
// Bus-side and char_buf-side signals of the text console controller.
//
// Handshake: do_write and do_read are single-cycle strobes with no ready.
// A write is consumed (applied, or dropped and flagged in ovf) on the clk
// edge that samples the strobe. read_data is combinational from r_adr so the
// bus slave can latch it one cycle after do_read. buf_w is a one-cycle write
// enable that the char_buf always accepts; w_row/w_col/buf_in are valid only
// while buf_w is high. clr_state shows the clear engine state for debug.
interface text_console_if #(
  parameter int AW = 8,
  parameter int DW = 16,
  parameter int RW = 7,
  parameter int CW = 7
);
  import text_console_pkg::*;

  logic          do_write;
  logic [AW-1:0] w_adr;
  logic [DW-1:0] w_data;
  logic          do_read;
  logic [AW-1:0] r_adr;
  logic [DW-1:0] read_data;
  logic          buf_w;
  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col;
  logic [7:0]    buf_in;
  logic          busy;
  clr_state_t    clr_state;

  modport master (
    output do_write, w_adr, w_data, do_read, r_adr,
    input  read_data, buf_w, w_row, w_col, buf_in, busy, clr_state
  );

  modport slave (
    input  do_write, w_adr, w_data, do_read, r_adr,
    output read_data, buf_w, w_row, w_col, buf_in, busy, clr_state
  );

endinterface

// File: rtl/text_console_ctrl_clear_sequencer.sv
// Clear engine: once started, walks every cell row-major from (0,0) to
// (COLS-1,ROWS-1), one cell per cycle. busy is high for exactly COLS*ROWS
// cycles; done marks the cycle that covers the final cell.
module clear_sequencer
  import text_console_pkg::*;
#(
  parameter int COLS = 80,
  parameter int ROWS = 64,
  parameter int CW   = 7,
  parameter int RW   = 7
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output clr_state_t    state
);

  logic last_col;
  logic last_row;

  assign last_col = (col == CW'(COLS - 1));
  assign last_row = (row == RW'(ROWS - 1));
  assign busy     = (state == CLR_RUN);
  assign done     = busy && last_col && last_row;

  // State and cell counter; start is ignored while a clear is running.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= CLR_IDLE;
      row   <= '0;
      col   <= '0;
    end else begin
      case (state)
        CLR_IDLE: begin
          if (start) begin
            state <= CLR_RUN;
            row   <= '0;
            col   <= '0;
          end
        end
        CLR_RUN: begin
          if (last_col) begin
            col <= '0;
            if (last_row) begin
              row   <= '0;
              state <= CLR_IDLE;
            end else begin
              row <= row + RW'(1);
            end
          end else begin
            col <= col + CW'(1);
          end
        end
        default: state <= CLR_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/text_console_ctrl.sv
// Register-mapped text console controller. Decodes bus writes into cursor,
// character and control operations, runs the clear engine, and muxes the
// single char_buf write port between character writes and the clear engine.
module text_console_ctrl
  import text_console_pkg::*;
#(
  parameter int AW   = 8,
  parameter int DW   = 16,
  parameter int COLS = 80,
  parameter int ROWS = 64,
  parameter int CW   = 7,
  parameter int RW   = 7
) (
  input  logic           clk,
  input  logic           nrst,
  text_console_if.slave  bus
);

  logic [CW-1:0] cur_x;
  logic [RW-1:0] cur_y;
  logic [7:0]    fill;
  logic [7:0]    clr_fill;
  logic          ovf;

  logic          chr_w;
  logic [RW-1:0] chr_row;
  logic [CW-1:0] chr_col;
  logic [7:0]    chr_data;

  logic          clr_busy;
  logic          clr_done;
  logic [RW-1:0] clr_row;
  logic [CW-1:0] clr_col;

  logic          wr_char;
  logic          wr_curx;
  logic          wr_cury;
  logic          wr_ctrl;
  logic          clr_start;
  logic [7:0]    ch;
  logic [RW-1:0] y_inc;
  logic          unused_ok;

  // do_read has no side effects here; it is kept only for bus symmetry.
  assign unused_ok = &{1'b0, bus.do_read};

  assign wr_char   = bus.do_write && (bus.w_adr == AW'(REG_CHAR));
  assign wr_curx   = bus.do_write && (bus.w_adr == AW'(REG_CURX));
  assign wr_cury   = bus.do_write && (bus.w_adr == AW'(REG_CURY));
  assign wr_ctrl   = bus.do_write && (bus.w_adr == AW'(REG_CTRL));
  assign clr_start = wr_ctrl && bus.w_data[CTRL_CLEAR_BIT] && !clr_busy;
  assign ch        = bus.w_data[7:0];
  assign y_inc     = (cur_y == RW'(ROWS - 1)) ? '0 : cur_y + RW'(1);

  clear_sequencer #(
    .COLS (COLS),
    .ROWS (ROWS),
    .CW   (CW),
    .RW   (RW)
  ) u_clear (
    .clk   (clk),
    .nrst  (nrst),
    .start (clr_start),
    .busy  (clr_busy),
    .done  (clr_done),
    .row   (clr_row),
    .col   (clr_col),
    .state (bus.clr_state)
  );

  // Cursor, fill, overflow flag and the one-cycle character write pulse.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      cur_x    <= '0;
      cur_y    <= '0;
      fill     <= FILL_RESET;
      clr_fill <= FILL_RESET;
      ovf      <= 1'b0;
      chr_w    <= 1'b0;
      chr_row  <= '0;
      chr_col  <= '0;
      chr_data <= '0;
    end else begin
      chr_w <= 1'b0;

      // The clear leaves the cursor home; bus cursor writes cannot collide
      // with this because they are dropped while busy.
      if (clr_done) begin
        cur_x <= '0;
        cur_y <= '0;
      end

      if (wr_char) begin
        if (clr_busy) begin
          ovf <= 1'b1;
        end else if (ch == CHAR_LF) begin
          cur_x <= '0;
          cur_y <= y_inc;
        end else if (ch == CHAR_CR) begin
          cur_x <= '0;
        end else begin
          chr_w    <= 1'b1;
          chr_row  <= cur_y;
          chr_col  <= cur_x;
          chr_data <= ch;
          if (cur_x == CW'(COLS - 1)) begin
            cur_x <= '0;
            cur_y <= y_inc;
          end else begin
            cur_x <= cur_x + CW'(1);
          end
        end
      end

      if (wr_curx) begin
        if (clr_busy) begin
          ovf <= 1'b1;
        end else if (bus.w_data > DW'(COLS - 1)) begin
          cur_x <= CW'(COLS - 1);
        end else begin
          cur_x <= bus.w_data[CW-1:0];
        end
      end

      if (wr_cury) begin
        if (clr_busy) begin
          ovf <= 1'b1;
        end else if (bus.w_data > DW'(ROWS - 1)) begin
          cur_y <= RW'(ROWS - 1);
        end else begin
          cur_y <= bus.w_data[RW-1:0];
        end
      end

      // Fill and ovf-clear apply even while busy; the running clear keeps
      // the fill value captured when it started.
      if (wr_ctrl) begin
        fill <= bus.w_data[15:8];
        if (bus.w_data[CTRL_OVF_CLR_BIT]) begin
          ovf <= 1'b0;
        end
        if (clr_start) begin
          clr_fill <= bus.w_data[15:8];
        end
      end
    end
  end

  // Register read mux, combinational so the bus slave can latch it later.
  always_comb begin
    bus.read_data = '0;
    if (bus.r_adr == AW'(REG_CURX)) begin
      bus.read_data = DW'(cur_x);
    end else if (bus.r_adr == AW'(REG_CURY)) begin
      bus.read_data = DW'(cur_y);
    end else if (bus.r_adr == AW'(REG_CTRL)) begin
      bus.read_data = DW'({fill, 8'h00});
    end else if (bus.r_adr == AW'(REG_STATUS)) begin
      bus.read_data = DW'({ovf, clr_busy});
    end
  end

  // Write port mux: the clear engine owns the port for its whole run, and a
  // character pulse can only be issued while idle, so the two never overlap.
  assign bus.buf_w  = clr_busy | chr_w;
  assign bus.w_row  = clr_busy ? clr_row  : chr_row;
  assign bus.w_col  = clr_busy ? clr_col  : chr_col;
  assign bus.buf_in = clr_busy ? clr_fill : chr_data;
  assign bus.busy   = clr_busy;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Self-checking bench for text_console_ctrl: directed bus writes, a
// cell-level model of the console producing the expected write stream per
// cycle, and register reads against model and literal values.
module tb_text_console_ctrl;
  import text_console_pkg::*;

  localparam int AW   = 8;
  localparam int DW   = 16;
  localparam int COLS = 80;
  localparam int ROWS = 64;
  localparam int CW   = 7;
  localparam int RW   = 7;

  logic clk;
  logic nrst;
  int   cyc;
  logic chk_en;
  int   checks;
  int   errors;

  // Expected char_buf writes: {cycle[31:0], row[6:0], col[6:0], data[7:0]}.
  logic [53:0] exp_q[$];

  // Model state.
  int       m_x;
  int       m_y;
  int       m_fill;
  int       m_ovf;
  int       clr_s;
  int       clr_e;

  text_console_if #(.AW(AW), .DW(DW), .RW(RW), .CW(CW)) bus ();

  text_console_ctrl #(
    .AW(AW), .DW(DW), .COLS(COLS), .ROWS(ROWS), .CW(CW), .RW(RW)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [53:0] mk(input logic [31:0] c, input int r, input int col, input logic [7:0] d);
    logic [6:0] r7;
    logic [6:0] c7;
    r7 = r[6:0];
    c7 = col[6:0];
    return {c, r7, c7, d};
  endfunction

  function automatic bit m_busy(input int c);
    return (c >= clr_s) && (c <= clr_e);
  endfunction

  // Console model: applies one bus write issued in cycle c.
  task automatic model_write(input logic [7:0] adr, input logic [15:0] data, input int c);
    bit b;
    int v;
    b = m_busy(c);
    if (adr == REG_CHAR) begin
      if (b) m_ovf = 1;
      else if (data[7:0] == 8'h0A) begin
        m_x = 0; m_y = (m_y + 1) % ROWS;
      end else if (data[7:0] == 8'h0D) begin
        m_x = 0;
      end else begin
        exp_q.push_back(mk(c + 1, m_y, m_x, data[7:0]));
        m_x = m_x + 1;
        if (m_x == COLS) begin
          m_x = 0; m_y = (m_y + 1) % ROWS;
        end
      end
    end else if (adr == REG_CURX || adr == REG_CURY) begin
      if (b) m_ovf = 1;
      else begin
        v = int'(data);
        if (adr == REG_CURX) m_x = (v > COLS - 1) ? COLS - 1 : v;
        else                 m_y = (v > ROWS - 1) ? ROWS - 1 : v;
      end
    end else if (adr == REG_CTRL) begin
      m_fill = int'(data[15:8]);
      if (data[1]) m_ovf = 0;
      if (data[0] && !b) begin
        clr_s = c + 1;
        clr_e = c + COLS * ROWS;
        for (int i = 0; i < COLS * ROWS; i++)
          exp_q.push_back(mk(c + 1 + i, i / COLS, i % COLS, data[15:8]));
        // Reads are only made after the clear ends, when the cursor is home.
        m_x = 0; m_y = 0;
      end
    end
  endtask

  function automatic logic [15:0] m_reg(input logic [7:0] adr);
    logic [7:0] f;
    f = m_fill[7:0];
    case (adr)
      REG_CURX:   return 16'(m_x);
      REG_CURY:   return 16'(m_y);
      REG_CTRL:   return {f, 8'h00};
      REG_STATUS: return 16'({m_ovf[0], m_busy(cyc)});
      default:    return 16'h0000;
    endcase
  endfunction

  // Driver tasks: each is entered and left 1 time unit after a posedge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] adr, input logic [15:0] data);
    bus.do_write = 1'b1;
    bus.w_adr    = adr;
    bus.w_data   = data;
    model_write(adr, data, cyc);
    @(posedge clk);
    #1;
    bus.do_write = 1'b0;
  endtask

  task automatic check_read(input string name, input logic [7:0] adr, input logic [15:0] exp);
    bus.r_adr   = adr;
    bus.do_read = 1'b1;
    #2;
    check(name, 64'(bus.read_data), 64'(exp));
    bus.do_read = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_reset();
    int c;
    c = cyc;
    nrst = 1'b0;
    while (exp_q.size() > 0 && int'(exp_q[$][53:22]) >= c + 1) void'(exp_q.pop_back());
    if (clr_e > c) clr_e = c;
    m_x = 0; m_y = 0; m_fill = 32'h20; m_ovf = 0;
    @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  // Scoreboard: every cycle, buf_w and busy must match the model's stream.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(bus.busy), 64'(m_busy(cyc)));
      if (exp_q.size() > 0 && int'(exp_q[0][53:22]) == cyc) begin
        check("buf_w", 64'(bus.buf_w), 64'd1);
        check("cell", 64'({bus.w_row, bus.w_col, bus.buf_in}), 64'(exp_q[0][21:0]));
        void'(exp_q.pop_front());
      end else begin
        check("buf_w_idle", 64'(bus.buf_w), 64'd0);
      end
    end
  end

  initial begin
    cyc = 0; chk_en = 1'b0; checks = 0; errors = 0;
    m_x = 0; m_y = 0; m_fill = 32'h20; m_ovf = 0; clr_s = 1; clr_e = 0;
    nrst = 1'b0;
    bus.do_write = 1'b0; bus.w_adr = '0; bus.w_data = '0;
    bus.do_read = 1'b0; bus.r_adr = '0;
    idle(3);

    // Reset state, literal.
    check("rst_buf_w", 64'(bus.buf_w), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_port", 64'({bus.w_row, bus.w_col, bus.buf_in}), 64'd0);
    check_read("rst_curx", REG_CURX, 16'h0000);
    check_read("rst_ctrl", REG_CTRL, 16'h2000);
    check_read("rst_status", REG_STATUS, 16'h0000);
    check_read("rst_other", 8'h05, 16'h0000);
    nrst = 1'b1;
    chk_en = 1'b1;
    idle(1);

    // Two characters at the home position.
    bus_write(REG_CHAR, 16'h0041);
    bus_write(REG_CHAR, 16'h0042);
    idle(1);
    check_read("curx_ab", REG_CURX, 16'd2);
    check_read("cury_ab", REG_CURY, m_reg(REG_CURY));

    // Bottom-right corner wraps to home; out-of-range X clamps.
    bus_write(REG_CURX, 16'd79);
    bus_write(REG_CURY, 16'd63);
    bus_write(REG_CHAR, 16'h005A);
    idle(1);
    check_read("curx_wrap", REG_CURX, 16'd0);
    check_read("cury_wrap", REG_CURY, 16'd0);
    bus_write(REG_CURX, 16'd200);
    check_read("curx_clamp", REG_CURX, 16'd79);
    bus_write(REG_CURY, 16'd1000);
    check_read("cury_clamp", REG_CURY, m_reg(REG_CURY));

    // Character then LF: one write, cursor to next row start.
    bus_write(REG_CURX, 16'd5);
    bus_write(REG_CURY, 16'd3);
    bus_write(REG_CHAR, 16'h0078);
    bus_write(REG_CHAR, 16'h000A);
    idle(1);
    check_read("curx_lf", REG_CURX, 16'd0);
    check_read("cury_lf", REG_CURY, 16'd4);
    bus_write(REG_CURX, 16'd7);
    bus_write(REG_CHAR, 16'h000D);
    idle(1);
    check_read("curx_cr", REG_CURX, 16'd0);
    check_read("cury_cr", REG_CURY, 16'd4);
    bus_write(8'h10, 16'h0041);
    check_read("ignored_adr", REG_CURX, m_reg(REG_CURX));

    // Full clear with fill 0x2E; drops, ovf, no restart while busy.
    bus_write(REG_CTRL, 16'h2E01);
    idle(2);
    check_read("status_busy", REG_STATUS, 16'h0001);
    bus_write(REG_CHAR, 16'h0051);
    check_read("status_ovf", REG_STATUS, 16'h0003);
    bus_write(REG_CTRL, 16'h0002);
    check_read("status_ovfclr", REG_STATUS, 16'h0001);
    bus_write(REG_CTRL, 16'h5501);
    check_read("ctrl_busy", REG_CTRL, 16'h5500);
    idle(COLS * ROWS);
    check_read("status_done", REG_STATUS, 16'h0000);
    check_read("curx_clr", REG_CURX, 16'd0);
    check_read("cury_clr", REG_CURY, m_reg(REG_CURY));
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a clear.
    bus_write(REG_CTRL, 16'h4101);
    idle(100);
    bus_reset();
    #2;
    check("midrst_buf_w", 64'(bus.buf_w), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    #1;
    idle(1);
    check_read("midrst_ctrl", REG_CTRL, 16'h2000);
    bus_write(REG_CHAR, 16'h004B);
    idle(2);
    check_read("midrst_curx", REG_CURX, 16'd1);
    check("queue_end", 64'(exp_q.size()), 64'd0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
